// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//   VGA raster timing generator and output stage for the RGB565 VGA path.
//   Two free-running counters (cnt_h per clock, cnt_v per line) set the raster
//   position. hsync, vsync and the active-area window are decoded from the
//   counters. Pixel coordinates are requested one clock before a pixel is
//   displayed, because the picture stage registers pix_data. This makes
//   pixel (x,y) arrive on the same clock that rgb_valid is high for column x.
//
// Ports
//   vga_clk      in   1   pixel clock
//   sys_rst_n    in   1   asynchronous, active-low reset
//   pix_data     in   16  RGB565 pixel from the picture stage (1-cycle latency)
//   pix_x        out  10  requested column, 10'h3FF when no request
//   pix_y        out  10  requested row,    10'h3FF when no request
//   hsync        out  1   horizontal sync, SYNC_POL during the sync segment
//   vsync        out  1   vertical sync,   SYNC_POL during the sync segment
//   rgb_valid    out  1   rgb carries an active-area pixel
//   rgb          out  16  RGB565 to the DAC, zero when rgb_valid is low
//   frame_start  out  1   one-clock pulse while the raster sits at (0,0)
//
// Handshake: there is no backpressure. pix_x/pix_y form a request that is
// implicitly accepted every clock, and pix_data must be valid exactly one
// clock after the request.
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter logic [9:0] H_SYNC   = 10'd96,
    parameter logic [9:0] H_BACK   = 10'd48,
    parameter logic [9:0] H_VALID  = 10'd640,
    parameter logic [9:0] H_FRONT  = 10'd16,
    parameter logic [9:0] V_SYNC   = 10'd2,
    parameter logic [9:0] V_BACK   = 10'd33,
    parameter logic [9:0] V_VALID  = 10'd480,
    parameter logic [9:0] V_FRONT  = 10'd10,
    parameter logic       SYNC_POL = 1'b0
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam logic [9:0] V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam logic [9:0] H_START = H_SYNC + H_BACK;
    localparam logic [9:0] V_START = V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST  = H_START + H_VALID - 10'd1;
    localparam logic [9:0] V_LAST  = V_START + V_VALID - 10'd1;
    // Request window is the display window moved one clock earlier.
    localparam logic [9:0] H_REQ_FIRST = H_START - 10'd1;
    localparam logic [9:0] H_REQ_LAST  = H_START + H_VALID - 10'd2;

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       h_wrap;
    logic       v_wrap;
    logic       v_active;
    logic       pix_req;

    assign h_wrap = (cnt_h == H_TOTAL - 10'd1);
    assign v_wrap = (cnt_v == V_TOTAL - 10'd1);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h       <= 10'd0;
            cnt_v       <= 10'd0;
            frame_start <= 1'b0;
        end else begin
            cnt_h <= h_wrap ? 10'd0 : cnt_h + 10'd1;
            if (h_wrap) begin
                cnt_v <= v_wrap ? 10'd0 : cnt_v + 10'd1;
            end
            // Raised on the wrap clock so it is high while the raster is at (0,0).
            frame_start <= h_wrap && v_wrap;
        end
    end

    assign v_active  = (cnt_v >= V_START) && (cnt_v <= V_LAST);
    assign rgb_valid = (cnt_h >= H_START) && (cnt_h <= H_LAST) && v_active;
    assign pix_req   = (cnt_h >= H_REQ_FIRST) && (cnt_h <= H_REQ_LAST) && v_active;

    assign pix_x = pix_req ? (cnt_h - H_REQ_FIRST) : 10'h3FF;
    assign pix_y = pix_req ? (cnt_v - V_START)     : 10'h3FF;

    assign hsync = (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vsync = (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL;

    assign rgb = rgb_valid ? pix_data : 16'h0000;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_ctrl
//   dut_s : reduced timing (17 x 9 raster, 8x4 active), SYNC_POL = 0,
//           fed by a registered coordinate pattern.
//   dut_p : same reduced timing, SYNC_POL = 1, pix_data held at 16'hFFFF.
//   dut_d : default 640x480 timing, fed by a registered red-column-0 pattern.
//   Reduced timing: H 4/3/8/2 (total 17, start 7), V 2/2/4/1 (total 9, start 4),
//   so one frame takes 153 clocks.
//   k counts rising edges since reset release. Outputs are sampled on the
//   falling edge, so at sample k the reduced-timing raster is at
//   (v,h) = ((k/17)%9, k%17).
// ---------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    logic        vga_clk;
    logic        sys_rst_n;

    logic [15:0] pd_s, pd_p, pd_d;
    logic [9:0]  pix_x_s, pix_y_s, pix_x_p, pix_y_p, pix_x_d, pix_y_d;
    logic        hsync_s, vsync_s, rgb_valid_s, frame_start_s;
    logic        hsync_p, vsync_p, rgb_valid_p, frame_start_p;
    logic        hsync_d, vsync_d, rgb_valid_d, frame_start_d;
    logic [15:0] rgb_s, rgb_p, rgb_d;

    int n_tests = 0;
    int n_fail  = 0;

    int hs_low_s = 0, vs_low_s = 0, rv_s = 0, fs_s = 0;
    int hs_high_p = 0, vs_high_p = 0, ok_p = 0, bad_p = 0, fs_p = 0;
    int hs_low_d = 0, vs_low_d = 0, rv_d = 0, bad_d = 0;

    // ---------------- clock ----------------
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // ---------------- DUTs ----------------
    vga_timing_ctrl #(
        .H_SYNC(10'd4), .H_BACK(10'd3), .H_VALID(10'd8), .H_FRONT(10'd2),
        .V_SYNC(10'd2), .V_BACK(10'd2), .V_VALID(10'd4), .V_FRONT(10'd1),
        .SYNC_POL(1'b0)
    ) dut_s (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pd_s),
        .pix_x(pix_x_s), .pix_y(pix_y_s), .hsync(hsync_s), .vsync(vsync_s),
        .rgb_valid(rgb_valid_s), .rgb(rgb_s), .frame_start(frame_start_s)
    );

    vga_timing_ctrl #(
        .H_SYNC(10'd4), .H_BACK(10'd3), .H_VALID(10'd8), .H_FRONT(10'd2),
        .V_SYNC(10'd2), .V_BACK(10'd2), .V_VALID(10'd4), .V_FRONT(10'd1),
        .SYNC_POL(1'b1)
    ) dut_p (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pd_p),
        .pix_x(pix_x_p), .pix_y(pix_y_p), .hsync(hsync_p), .vsync(vsync_p),
        .rgb_valid(rgb_valid_p), .rgb(rgb_p), .frame_start(frame_start_p)
    );

    vga_timing_ctrl dut_d (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pd_d),
        .pix_x(pix_x_d), .pix_y(pix_y_d), .hsync(hsync_d), .vsync(vsync_d),
        .rgb_valid(rgb_valid_d), .rgb(rgb_d), .frame_start(frame_start_d)
    );

    // Upstream picture stages: one register between request and pixel.
    assign pd_p = 16'hFFFF;
    always_ff @(posedge vga_clk) begin
        pd_s <= {1'b1, pix_y_s[4:0], pix_x_s};
        pd_d <= (pix_x_d == 10'd0) ? 16'hF800 : 16'h07E0;
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-sample bookkeeping and directed point checks.
    task automatic sample(input int k);
        if (k <= 305) begin
            if (hsync_s == 1'b0)   hs_low_s++;
            if (vsync_s == 1'b0)   vs_low_s++;
            if (rgb_valid_s)       rv_s++;
            if (hsync_p == 1'b1)   hs_high_p++;
            if (vsync_p == 1'b1)   vs_high_p++;
            if (rgb_valid_p && rgb_p == 16'hFFFF) ok_p++;
        end
        if (k <= 306) begin
            if (frame_start_s) fs_s++;
            if (frame_start_p) fs_p++;
        end
        if (!rgb_valid_p && rgb_p != 16'h0000) bad_p++;
        if (!rgb_valid_d && rgb_d != 16'h0000) bad_d++;
        if (k < 800   && hsync_d == 1'b0) hs_low_d++;
        if (k < 28000 && vsync_d == 1'b0) vs_low_d++;
        if (k < 28000 && rgb_valid_d)     rv_d++;

        case (k)
            0:   check_eq("fs_after_release", {31'd0, frame_start_s}, 32'd0);
            57:  check_eq("pix_x_before_vstart", {22'd0, pix_x_s}, 32'h3FF);   // (3,6)
            74: begin                                                          // (4,6)
                check_eq("first_pix_x", {22'd0, pix_x_s}, 32'd0);
                check_eq("first_pix_y", {22'd0, pix_y_s}, 32'd0);
                check_eq("first_rv_low", {31'd0, rgb_valid_s}, 32'd0);
            end
            75: begin                                                          // (4,7)
                check_eq("first_rv", {31'd0, rgb_valid_s}, 32'd1);
                check_eq("first_rgb", {16'd0, rgb_s}, 32'h8000);
            end
            95: begin                                                          // (5,10)
                check_eq("mid_pix_x", {22'd0, pix_x_s}, 32'd4);
                check_eq("mid_pix_y", {22'd0, pix_y_s}, 32'd1);
                check_eq("mid_rgb", {16'd0, rgb_s}, 32'h8403);
            end
            132: begin                                                         // (7,13)
                check_eq("last_pix_x", {22'd0, pix_x_s}, 32'd7);
                check_eq("last_pix_y", {22'd0, pix_y_s}, 32'd3);
            end
            133: begin                                                         // (7,14)
                check_eq("last_rv", {31'd0, rgb_valid_s}, 32'd1);
                check_eq("last_rgb", {16'd0, rgb_s}, 32'h8C07);
                check_eq("last_req_drop", {22'd0, pix_x_s}, 32'h3FF);
            end
            134: begin                                                         // (7,15)
                check_eq("after_last_rv", {31'd0, rgb_valid_s}, 32'd0);
                check_eq("after_last_rgb", {16'd0, rgb_s}, 32'h0);
                check_eq("after_last_pix_x", {22'd0, pix_x_s}, 32'h3FF);
            end
            143: check_eq("front_porch_rv", {31'd0, rgb_valid_s}, 32'd0);   // (8,7)
            153: check_eq("fs_pulse", {31'd0, frame_start_s}, 32'd1);
            154: check_eq("fs_one_clock", {31'd0, frame_start_s}, 32'd0);
            28143: begin                                                       // default (35,143)
                check_eq("d_first_pix_x", {22'd0, pix_x_d}, 32'd0);
                check_eq("d_first_pix_y", {22'd0, pix_y_d}, 32'd0);
            end
            28144: begin                                                       // default (35,144)
                check_eq("d_first_rv", {31'd0, rgb_valid_d}, 32'd1);
                check_eq("d_first_rgb", {16'd0, rgb_d}, 32'hF800);
            end
            28145: check_eq("d_second_rgb", {16'd0, rgb_d}, 32'h07E0);
            default: ;
        endcase
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int wait_cnt;
        bit seen;

        sys_rst_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        check_eq("rst_hsync_s", {31'd0, hsync_s}, 32'd0);
        check_eq("rst_vsync_s", {31'd0, vsync_s}, 32'd0);
        check_eq("rst_hsync_p", {31'd0, hsync_p}, 32'd1);
        check_eq("rst_rv", {31'd0, rgb_valid_s}, 32'd0);
        check_eq("rst_pix_x", {22'd0, pix_x_s}, 32'h3FF);
        check_eq("rst_pix_y", {22'd0, pix_y_s}, 32'h3FF);
        check_eq("rst_rgb", {16'd0, rgb_s}, 32'h0);
        check_eq("rst_fs", {31'd0, frame_start_s}, 32'd0);

        sys_rst_n = 1'b1;
        k = 0;
        sample(k);
        while (k < 28145) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            k++;
            sample(k);
        end

        check_eq("hs_low_s_2frames", hs_low_s, 72);
        check_eq("vs_low_s_2frames", vs_low_s, 68);
        check_eq("rv_s_2frames", rv_s, 64);
        check_eq("fs_s_count", fs_s, 2);
        check_eq("hs_high_p_2frames", hs_high_p, 72);
        check_eq("vs_high_p_2frames", vs_high_p, 68);
        check_eq("fs_p_count", fs_p, 2);
        check_eq("p_valid_ffff", ok_p, 64);
        check_eq("hs_low_d_line", hs_low_d, 96);
        check_eq("vs_low_d_35lines", vs_low_d, 1600);
        check_eq("rv_d_porch", rv_d, 0);

        // Advance to reduced-timing position (5,9), i.e. mid-line.
        while ((k % 153) != 94) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            k++;
            sample(k);
        end
        check_eq("blank_p", bad_p, 0);
        check_eq("blank_d", bad_d, 0);
        check_eq("pre_rst_cnt_h", {22'd0, dut_s.cnt_h}, 32'd9);

        // Asynchronous reset in the middle of the low clock phase.
        #2 sys_rst_n = 1'b0;
        #1;
        check_eq("async_cnt_h", {22'd0, dut_s.cnt_h}, 32'd0);
        check_eq("async_cnt_v", {22'd0, dut_s.cnt_v}, 32'd0);
        check_eq("async_pix_x", {22'd0, pix_x_s}, 32'h3FF);
        check_eq("async_hsync", {31'd0, hsync_s}, 32'd0);
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;

        wait_cnt = 0;
        seen = 1'b0;
        while (!seen && wait_cnt < 400) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            wait_cnt++;
            if (frame_start_s) seen = 1'b1;
        end
        check_eq("fs_seen_after_rst", {31'd0, seen}, 32'd1);
        check_eq("fs_delay_after_rst", wait_cnt, 153);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
